// File: rtl/fir_decim_avl.sv
// Avalon-ST payload decimator placed after the low-pass FIR packet unit.
// Header and trailer words pass through unchanged; payload keeps one sample in every FACTOR.
//
// state   | meaning
// IDLE    | waiting for a SOP beat
// HEADER  | forwarding header words
// PAYLOAD | decimating payload samples until EOP
// RESYNC  | synthetic trailer pushed, pending SOP beat still to be pushed
module fir_decim_avl #(
   parameter int FACTOR       = 2,
   parameter int DATA_WIDTH   = 16,
   parameter int HEADER_WORDS = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  data_input_ready,
   input  logic                  data_input_valid,
   input  logic                  data_input_startofpacket,
   input  logic                  data_input_endofpacket,
   input  logic [DATA_WIDTH-1:0] data_input_data,
   input  logic                  data_output_ready,
   output logic                  data_output_valid,
   output logic                  data_output_startofpacket,
   output logic                  data_output_endofpacket,
   output logic [DATA_WIDTH-1:0] data_output_data,
   output logic [15:0]           kept_count,
   output logic                  protocol_error
);

   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, RESYNC} state_t;

   localparam logic [7:0] PHASE_LAST = 8'(FACTOR - 1);
   localparam logic [3:0] HDR_LAST   = 4'(HEADER_WORDS);
   localparam state_t     AFTER_SOP  = (HEADER_WORDS > 1) ? HEADER : PAYLOAD;
   localparam int         EW         = DATA_WIDTH + 2;

   state_t                state;
   logic [3:0]            hdr_cnt;
   logic [7:0]            phase;
   logic [15:0]           kcnt;
   logic [DATA_WIDTH-1:0] pend_data;
   logic                  pend_eop;

   // skid buffer entries are {sop, eop, data}; ent0 is the head driven onto the source
   logic [EW-1:0]         ent0, ent1;
   logic [1:0]            count, count_nxt;

   logic                  accept, pop, push, err, resync_nxt, start_pkt, start_eop;
   logic [EW-1:0]         push_ent;
   logic [3:0]            hdr_inc;

   assign accept  = data_input_valid & data_input_ready;
   assign pop     = data_output_valid & data_output_ready;
   assign hdr_inc = hdr_cnt + 4'd1;

   assign data_output_valid = (count != 2'd0);
   assign {data_output_startofpacket, data_output_endofpacket, data_output_data} = ent0;

   always_comb begin
      push     = 1'b0;
      push_ent = '0;
      err      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (data_input_startofpacket) begin
                  push     = 1'b1;
                  push_ent = {1'b1, data_input_endofpacket, data_input_data};
               end else begin
                  err = 1'b1;
               end
            end
         end
         HEADER, PAYLOAD: begin
            if (accept) begin
               if (data_input_startofpacket) begin
                  push     = 1'b1;
                  push_ent = {1'b0, 1'b1, {DATA_WIDTH{1'b1}}};
                  err      = 1'b1;
               end else if (data_input_endofpacket) begin
                  push     = 1'b1;
                  push_ent = {1'b0, 1'b1, data_input_data};
               end else if (state == HEADER || phase == 8'd0) begin
                  push     = 1'b1;
                  push_ent = {1'b0, 1'b0, data_input_data};
               end
            end
         end
         RESYNC: begin
            if (count != 2'd2 || pop) begin
               push     = 1'b1;
               push_ent = {1'b1, pend_eop, pend_data};
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 2'd1;
         2'b01:   count_nxt = count - 2'd1;
         default: count_nxt = count;
      endcase
   end

   // a pending resync push needs a free slot, so input stays stalled until it lands
   assign resync_nxt = ((state == HEADER || state == PAYLOAD) && accept && data_input_startofpacket)
                       || (state == RESYNC && !push);
   assign start_pkt  = (state == IDLE && accept && data_input_startofpacket) || (state == RESYNC && push);
   assign start_eop  = (state == RESYNC) ? pend_eop : data_input_endofpacket;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         hdr_cnt          <= '0;
         phase            <= '0;
         kcnt             <= '0;
         pend_data        <= '0;
         pend_eop         <= 1'b0;
         kept_count       <= '0;
         protocol_error   <= 1'b0;
         data_input_ready <= 1'b0;
      end else begin
         protocol_error   <= err;
         data_input_ready <= !resync_nxt && (count_nxt != 2'd2);
         if (start_pkt) begin
            hdr_cnt <= 4'd1;
            phase   <= '0;
            kcnt    <= '0;
            state   <= start_eop ? IDLE : AFTER_SOP;
         end else if (accept && (state == HEADER || state == PAYLOAD)) begin
            if (data_input_startofpacket) begin
               pend_data <= data_input_data;
               pend_eop  <= data_input_endofpacket;
               state     <= RESYNC;
            end else if (data_input_endofpacket) begin
               if (state == PAYLOAD) kept_count <= kcnt;
               state <= IDLE;
            end else if (state == HEADER) begin
               hdr_cnt <= hdr_inc;
               if (hdr_inc == HDR_LAST) begin
                  state <= PAYLOAD;
                  phase <= '0;
                  kcnt  <= '0;
               end
            end else begin
               if (phase == 8'd0 && kcnt != 16'hFFFF) kcnt <= kcnt + 16'd1;
               phase <= (phase == PHASE_LAST) ? 8'd0 : phase + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ent0  <= '0;
         ent1  <= '0;
         count <= '0;
      end else begin
         count <= count_nxt;
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) ent0 <= push_ent;
               else               ent1 <= push_ent;
            end
            2'b01: ent0 <= ent1;
            2'b11: begin
               if (count == 2'd1) begin
                  ent0 <= push_ent;
               end else begin
                  ent0 <= ent1;
                  ent1 <= push_ent;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_decim_avl.sv
// Directed bench for fir_decim_avl: a FACTOR=2 instance and a FACTOR=3 instance share
// the stimulus bus; sel picks which one is driven and observed.
module tb_fir_decim_avl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        sel;
   logic        in_valid, in_sop, in_eop, out_ready;
   logic [15:0] in_data;

   logic        r2, v2, s2, e2, p2, r3, v3, s3, e3, p3;
   logic [15:0] d2, k2, d3, k3;

   logic        in_ready, o_valid, o_sop, o_eop, o_perr;
   logic [15:0] o_data, o_kept;

   assign in_ready = sel ? r3 : r2;
   assign o_valid  = sel ? v3 : v2;
   assign o_sop    = sel ? s3 : s2;
   assign o_eop    = sel ? e3 : e2;
   assign o_data   = sel ? d3 : d2;
   assign o_kept   = sel ? k3 : k2;
   assign o_perr   = sel ? p3 : p2;

   fir_decim_avl #(.FACTOR(2), .DATA_WIDTH(16), .HEADER_WORDS(2)) dut2 (
      .clk(clk), .reset(reset),
      .data_input_ready(r2), .data_input_valid(in_valid & ~sel),
      .data_input_startofpacket(in_sop), .data_input_endofpacket(in_eop), .data_input_data(in_data),
      .data_output_ready(out_ready), .data_output_valid(v2),
      .data_output_startofpacket(s2), .data_output_endofpacket(e2), .data_output_data(d2),
      .kept_count(k2), .protocol_error(p2));

   fir_decim_avl #(.FACTOR(3), .DATA_WIDTH(16), .HEADER_WORDS(2)) dut3 (
      .clk(clk), .reset(reset),
      .data_input_ready(r3), .data_input_valid(in_valid & sel),
      .data_input_startofpacket(in_sop), .data_input_endofpacket(in_eop), .data_input_data(in_data),
      .data_output_ready(out_ready), .data_output_valid(v3),
      .data_output_startofpacket(s3), .data_output_endofpacket(e3), .data_output_data(d3),
      .kept_count(k3), .protocol_error(p3));

   int checks = 0;
   int errors = 0;

   logic [18:0] tx_q[$];   // {forwarded, sop, eop, data}
   logic [17:0] rx_q[$];   // {sop, eop, data}
   logic [17:0] exp_q[$];
   logic        cur_fwd = 1'b0;
   int          perr_cnt = 0;
   int          occ = 0;
   int          occ_viol = 0;
   bit          occ_en = 1'b0;
   int          bp_mode = 0;
   int          bp_cyc = 0;

   function automatic logic [18:0] bt(input bit f, input bit s, input bit e, input logic [15:0] d);
      return {f, s, e, d};
   endfunction

   // output beats, error pulses and occupancy are all sampled on pre-edge values
   always @(posedge clk) begin
      if (o_valid && out_ready) rx_q.push_back({o_sop, o_eop, o_data});
      if (o_perr) perr_cnt++;
      if (occ_en) begin
         if (in_ready && occ >= 2) occ_viol++;
         if (in_valid && in_ready && cur_fwd) occ++;
         if (o_valid && out_ready) occ--;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         bp_cyc++;
         case (bp_mode)
            0: out_ready = 1'b1;
            1: out_ready = ((bp_cyc % 4) == 0) || ((bp_cyc % 4) == 3);
            default: out_ready = 1'b0;
         endcase
      end
   end

   task automatic drive_tx();
      logic [18:0] b;
      int n;
      @(negedge clk);
      while (tx_q.size() > 0) begin
         b        = tx_q.pop_front();
         cur_fwd  = b[18];
         in_sop   = b[17];
         in_eop   = b[16];
         in_data  = b[15:0];
         in_valid = 1'b1;
         n = 0;
         do begin
            @(posedge clk);
            n++;
         end while (!in_ready && n < 200);
         if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL drive_timeout data=%h ready never rose", in_data);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      cur_fwd  = 1'b0;
   endtask

   task automatic wait_rx(input int n);
      int k = 0;
      while (rx_q.size() < n && k < 300) begin
         @(negedge clk);
         k++;
      end
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; sel = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
      out_ready = 1'b1;
      #12;
      checks++;
      if ({r2, v2, s2, e2, d2, k2, p2} !== '0) begin
         errors++;
         $display("FAIL reset_outputs_f2 got %h required 0", {r2, v2, s2, e2, d2, k2, p2});
      end
      checks++;
      if ({r3, v3, s3, e3, d3, k3, p3} !== '0) begin
         errors++;
         $display("FAIL reset_outputs_f3 got %h required 0", {r3, v3, s3, e3, d3, k3, p3});
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({r2, r3, v2, v3} !== 4'b1100) begin
         errors++;
         $display("FAIL reset_release_ready got %b required 1100", {r2, r3, v2, v3});
      end
   endtask

   task automatic test_decimate();
      sel = 1'b0; bp_mode = 0;
      rx_q.delete(); exp_q.delete(); perr_cnt = 0;
      tx_q = '{bt(1,1,0,16'hA001), bt(1,0,0,16'h0005), bt(1,0,0,16'd10), bt(0,0,0,16'd20),
               bt(1,0,0,16'd30), bt(0,0,0,16'd40), bt(1,0,0,16'd50), bt(1,0,1,16'h1234)};
      exp_q = '{{2'b10,16'hA001}, {2'b00,16'h0005}, {2'b00,16'd10}, {2'b00,16'd30},
                {2'b00,16'd50}, {2'b01,16'h1234}};
      drive_tx();
      wait_rx(exp_q.size());
      checks++;
      if (rx_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL decim_count got %0d beats required %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL decim_beat%0d got sop=%b eop=%b data=%h required sop=%b eop=%b data=%h",
                     i, rx_q[i][17], rx_q[i][16], rx_q[i][15:0], exp_q[i][17], exp_q[i][16], exp_q[i][15:0]);
         end
      end
      checks++;
      if (o_kept !== 16'd3) begin
         errors++;
         $display("FAIL decim_kept got %0d required 3", o_kept);
      end
      checks++;
      if (perr_cnt !== 0) begin
         errors++;
         $display("FAIL decim_perr got %0d pulses required 0", perr_cnt);
      end
   endtask

   task automatic test_backpressure();
      sel = 1'b0;
      rx_q.delete(); exp_q.delete();
      occ = 0; occ_viol = 0; occ_en = 1'b1;
      bp_cyc = 0; bp_mode = 1;
      tx_q = '{bt(1,1,0,16'hA001), bt(1,0,0,16'h0005), bt(1,0,0,16'd10), bt(0,0,0,16'd20),
               bt(1,0,0,16'd30), bt(0,0,0,16'd40), bt(1,0,0,16'd50), bt(1,0,1,16'h1234)};
      exp_q = '{{2'b10,16'hA001}, {2'b00,16'h0005}, {2'b00,16'd10}, {2'b00,16'd30},
                {2'b00,16'd50}, {2'b01,16'h1234}};
      drive_tx();
      wait_rx(exp_q.size());
      occ_en = 1'b0;
      bp_mode = 0;
      checks++;
      if (rx_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL bp_count got %0d beats required %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL bp_beat%0d got sop=%b eop=%b data=%h required sop=%b eop=%b data=%h",
                     i, rx_q[i][17], rx_q[i][16], rx_q[i][15:0], exp_q[i][17], exp_q[i][16], exp_q[i][15:0]);
         end
      end
      checks++;
      if (occ_viol !== 0) begin
         errors++;
         $display("FAIL bp_ready_when_full got %0d cycles required 0", occ_viol);
      end
      checks++;
      if (o_kept !== 16'd3) begin
         errors++;
         $display("FAIL bp_kept got %0d required 3", o_kept);
      end
   endtask

   task automatic test_header_eop();
      sel = 1'b0; bp_mode = 0;
      rx_q.delete(); perr_cnt = 0;
      tx_q  = '{bt(1,1,0,16'hA001), bt(1,0,1,16'hBEEF)};
      exp_q = '{{2'b10,16'hA001}, {2'b01,16'hBEEF}};
      drive_tx();
      wait_rx(exp_q.size());
      checks++;
      if (rx_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL hdr_eop_count got %0d beats required %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL hdr_eop_beat%0d got sop=%b eop=%b data=%h required sop=%b eop=%b data=%h",
                     i, rx_q[i][17], rx_q[i][16], rx_q[i][15:0], exp_q[i][17], exp_q[i][16], exp_q[i][15:0]);
         end
      end
      checks++;
      if (o_kept !== 16'd3) begin
         errors++;
         $display("FAIL hdr_eop_kept got %0d required 3", o_kept);
      end
   endtask

   task automatic test_no_sop();
      sel = 1'b0; bp_mode = 0;
      rx_q.delete(); perr_cnt = 0;
      tx_q = '{bt(0,0,0,16'h5555)};
      drive_tx();
      wait_rx(1);
      checks++;
      if (rx_q.size() !== 0) begin
         errors++;
         $display("FAIL no_sop_output got %0d beats required 0", rx_q.size());
      end
      checks++;
      if (perr_cnt !== 1) begin
         errors++;
         $display("FAIL no_sop_perr got %0d pulse cycles required 1", perr_cnt);
      end
   endtask

   task automatic test_resync();
      sel = 1'b1; bp_mode = 0;
      rx_q.delete(); perr_cnt = 0;
      tx_q  = '{bt(1,1,0,16'hA001), bt(1,0,0,16'h0005), bt(1,0,0,16'h0001), bt(0,0,0,16'h0002),
                bt(0,0,0,16'h0003), bt(1,1,0,16'hC001), bt(1,0,0,16'h0006), bt(1,0,0,16'h0007),
                bt(1,0,1,16'h00EE)};
      exp_q = '{{2'b10,16'hA001}, {2'b00,16'h0005}, {2'b00,16'h0001}, {2'b01,16'hFFFF},
                {2'b10,16'hC001}, {2'b00,16'h0006}, {2'b00,16'h0007}, {2'b01,16'h00EE}};
      drive_tx();
      wait_rx(exp_q.size());
      checks++;
      if (rx_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL resync_count got %0d beats required %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL resync_beat%0d got sop=%b eop=%b data=%h required sop=%b eop=%b data=%h",
                     i, rx_q[i][17], rx_q[i][16], rx_q[i][15:0], exp_q[i][17], exp_q[i][16], exp_q[i][15:0]);
         end
      end
      checks++;
      if (perr_cnt !== 1) begin
         errors++;
         $display("FAIL resync_perr got %0d pulse cycles required 1", perr_cnt);
      end
      checks++;
      if (o_kept !== 16'd1) begin
         errors++;
         $display("FAIL resync_kept got %0d required 1", o_kept);
      end
      sel = 1'b0;
   endtask

   task automatic test_reset_mid();
      sel = 1'b0; bp_mode = 2; out_ready = 1'b0;
      rx_q.delete(); perr_cnt = 0;
      tx_q = '{bt(1,1,0,16'hA001), bt(1,0,0,16'h0005)};
      drive_tx();
      checks++;
      if ({o_valid, in_ready} !== 2'b10) begin
         errors++;
         $display("FAIL mid_full got valid,ready=%b required 10", {o_valid, in_ready});
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({r2, v2, s2, e2, d2, k2, p2} !== '0) begin
         errors++;
         $display("FAIL mid_async_reset got %h required 0", {r2, v2, s2, e2, d2, k2, p2});
      end
      @(negedge clk);
      reset = 1'b0;
      bp_mode = 0;
      rx_q.delete();
      tx_q  = '{bt(1,1,0,16'hA002), bt(1,0,0,16'h0007), bt(1,0,0,16'h0005), bt(0,0,0,16'h0006),
                bt(1,0,1,16'h00AA)};
      exp_q = '{{2'b10,16'hA002}, {2'b00,16'h0007}, {2'b00,16'h0005}, {2'b01,16'h00AA}};
      drive_tx();
      wait_rx(exp_q.size());
      checks++;
      if (rx_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL mid_after_count got %0d beats required %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL mid_after_beat%0d got sop=%b eop=%b data=%h required sop=%b eop=%b data=%h",
                     i, rx_q[i][17], rx_q[i][16], rx_q[i][15:0], exp_q[i][17], exp_q[i][16], exp_q[i][15:0]);
         end
      end
      checks++;
      if (o_kept !== 16'd1) begin
         errors++;
         $display("FAIL mid_after_kept got %0d required 1", o_kept);
      end
      checks++;
      if (perr_cnt !== 0) begin
         errors++;
         $display("FAIL mid_after_perr got %0d pulse cycles required 0", perr_cnt);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_decimate();
      test_backpressure();
      test_header_eop();
      test_no_sop();
      test_resync();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
